// File: rtl/inst_prefetch_if.sv
// Bundles the prefetch unit's redirect, arbiter client and decode-side signals.
// master = prefetch unit, slave = surrounding core (arbiter, execute, decode).
interface inst_prefetch_if #(
    parameter int M_WIDTH    = 32,
    parameter int INST_WIDTH = 32,
    parameter int CNT_W      = 3
);
    logic                  flush;
    logic [M_WIDTH-1:0]    flush_pc;
    logic                  mem_req;
    logic [M_WIDTH-1:0]    mem_addr;
    logic                  mem_ready;
    logic [M_WIDTH-1:0]    mem_data_in;
    logic                  out_valid;
    logic [INST_WIDTH-1:0] out_inst;
    logic [M_WIDTH-1:0]    out_pc;
    logic                  out_pop;
    logic [CNT_W-1:0]      count;

    modport master (
        input  flush, flush_pc, mem_ready, mem_data_in, out_pop,
        output mem_req, mem_addr, out_valid, out_inst, out_pc, count
    );

    modport slave (
        output flush, flush_pc, mem_ready, mem_data_in, out_pop,
        input  mem_req, mem_addr, out_valid, out_inst, out_pc, count
    );
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: fetches sequential words ahead of decode into a PC-tagged FIFO.
// Optional PREFETCH_STATS_EN adds saturating fetched/discarded word counters.
//
// state | meaning
// IDLE  | no request outstanding; waiting for queue space
// REQ   | read outstanding at mem_addr_q, mem_req held
// DROP  | flushed while outstanding; swallow the returning word
module inst_prefetch #(
    parameter int unsigned          M_WIDTH    = 32,
    parameter int unsigned          INST_WIDTH = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [M_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    inst_prefetch_if.master  pf_if
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]      stat_fetched_o,
    output logic [31:0]      stat_discarded_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [M_WIDTH-1:0] STEP = M_WIDTH'(INST_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e             state_q, state_d;
    logic [M_WIDTH-1:0] next_pc_q, next_pc_d;
    logic [M_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    logic [M_WIDTH-1:0]    pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic          pop, push, space_after;
    logic [CW-1:0] count_after;

    assign pop         = pf_if.out_pop && (count_q != '0);
    assign push        = (state_q == REQ) && pf_if.mem_ready && !pf_if.flush;
    assign count_after = count_q + CW'(push) - CW'(pop);
    // The outstanding request reserves a slot, so issue only if one remains free.
    assign space_after = count_after < CW'(DEPTH);

    always_comb begin
        state_d    = state_q;
        next_pc_d  = next_pc_q;
        mem_addr_d = mem_addr_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_after;
        case (state_q)
            IDLE: begin
                if (pf_if.flush) begin
                    next_pc_d = pf_if.flush_pc;
                end else if (space_after) begin
                    state_d    = REQ;
                    mem_addr_d = next_pc_q;
                end
            end
            REQ: begin
                if (pf_if.flush) begin
                    next_pc_d = pf_if.flush_pc;
                    state_d   = pf_if.mem_ready ? IDLE : DROP;
                end else if (pf_if.mem_ready) begin
                    next_pc_d = mem_addr_q + STEP;
                    if (space_after) begin
                        mem_addr_d = mem_addr_q + STEP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (pf_if.flush) begin
                    next_pc_d = pf_if.flush_pc;
                end
                if (pf_if.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pf_if.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            next_pc_q  <= RESET_PC;
            mem_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            next_pc_q  <= next_pc_d;
            mem_addr_q <= mem_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            pc_mem[wr_ptr_q]   <= mem_addr_q;
            inst_mem[wr_ptr_q] <= pf_if.mem_data_in[INST_WIDTH-1:0];
        end
    end

    assign pf_if.mem_req   = (state_q == REQ);
    assign pf_if.mem_addr  = mem_addr_q;
    assign pf_if.out_valid = (count_q != '0);
    assign pf_if.out_inst  = inst_mem[rd_ptr_q];
    assign pf_if.out_pc    = pc_mem[rd_ptr_q];
    assign pf_if.count     = count_q;

`ifdef PREFETCH_STATS_EN
    logic [31:0] fetched_q, discarded_q;
    logic [32:0] disc_inc, disc_sum;

    // Queued words the consumer did not take, plus the word still owed by the arbiter.
    assign disc_inc = 33'(count_q) - 33'(pop) + 33'(state_q == REQ);
    assign disc_sum = {1'b0, discarded_q} + disc_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetched_q   <= '0;
            discarded_q <= '0;
        end else begin
            if (push && (fetched_q != '1)) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (pf_if.flush) begin
                discarded_q <= disc_sum[32] ? '1 : disc_sum[31:0];
            end
        end
    end

    assign stat_fetched_o   = fetched_q;
    assign stat_discarded_o = discarded_q;
`endif
endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized bench for inst_prefetch: memory responder plus a queue-level reference model.
// Stats ports are connected and checked when PREFETCH_STATS_EN is defined.
module tb_inst_prefetch;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_prefetch_if #(.M_WIDTH(32), .INST_WIDTH(32), .CNT_W(CW)) pf ();

`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_f, stat_d;
`endif

    inst_prefetch #(.M_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pf_if (pf)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_fetched_o   (stat_f),
        .stat_discarded_o (stat_d)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      q[$];
    logic [31:0] exp_pc, out_addr, force_pc, force_data;
    bit          outst, disc_pend, exp_req, force_flush, use_force_data, stray_ready;
    int          lat_cnt;
    int unsigned pop_pct, flush_pct, lat_min, lat_max;
    longint      m_fetched, m_disc;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset(input bit stray);
        rst = 1'b1;
        pf.flush = 1'b0; pf.flush_pc = '0; pf.mem_ready = 1'b0;
        pf.mem_data_in = '0; pf.out_pop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_pc = 32'h0; outst = 0; disc_pend = 0; exp_req = 0;
        m_fetched = 0; m_disc = 0; stray_ready = stray;
    endtask

    // Called at a falling edge: check outputs, drive next inputs, advance the model.
    task automatic cycle();
        bit          pop, fl, rdy, was_pend, was_out;
        logic [31:0] d, fpc;
        chk("count", 64'(pf.count), 64'(q.size()));
        chk("out_valid", 64'(pf.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_pc", 64'(pf.out_pc), 64'(q[0].pc));
            chk("out_inst", 64'(pf.out_inst), 64'(q[0].inst));
        end
        chk("mem_req", 64'(pf.mem_req), 64'(exp_req));
        if (pf.mem_req) begin
            if (!outst) begin
                chk("req_addr", 64'(pf.mem_addr), 64'(exp_pc));
                outst    = 1;
                out_addr = pf.mem_addr;
                lat_cnt  = int'($urandom_range(lat_max, lat_min));
            end else begin
                chk("addr_hold", 64'(pf.mem_addr), 64'(out_addr));
            end
        end
`ifdef PREFETCH_STATS_EN
        chk("stat_fetched", 64'(stat_f), 64'(m_fetched));
        chk("stat_discarded", 64'(stat_d), 64'(m_disc));
`endif
        pop = ($urandom_range(99) < pop_pct);
        fl  = force_flush || ($urandom_range(99) < flush_pct);
        if (force_flush) fpc = force_pc;
        else if ($urandom_range(3) == 0) fpc = 32'hFFFF_FFF4;
        else fpc = $urandom & 32'hFFFF_FFFC;
        force_flush = 0;
        rdy = 0;
        if (outst) begin
            if (lat_cnt == 0) rdy = 1;
            else lat_cnt--;
        end
        if (stray_ready) begin
            rdy = 1;
            stray_ready = 0;
        end
        d = use_force_data ? force_data : $urandom;
        pf.out_pop = pop; pf.flush = fl; pf.flush_pc = fpc;
        pf.mem_ready = rdy; pf.mem_data_in = d;

        was_pend = disc_pend;
        was_out  = outst;
        if (pop && q.size() != 0) void'(q.pop_front());
        if (rdy && outst) begin
            outst = 0;
            disc_pend = 0;
            if (!fl && !was_pend) begin
                q.push_back('{pc: out_addr, inst: d});
                exp_pc = out_addr + 32'd4;
                m_fetched++;
            end
        end
        if (fl) begin
            m_disc += longint'(q.size()) + ((was_out && !was_pend) ? 1 : 0);
            q.delete();
            exp_pc = fpc;
            if (outst) disc_pend = 1;
        end
        exp_req = !fl && !(rdy && was_pend) && !disc_pend && (q.size() < DEPTH);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        force_flush = 0; use_force_data = 0; stray_ready = 0;
        pop_pct = 0; flush_pct = 0; lat_min = 1; lat_max = 1;
        @(negedge clk);

        // Fill with one-cycle memory and no consumer.
        do_reset(0);
        chk("rst_req", 64'(pf.mem_req), 64'd0);
        chk("rst_addr", 64'(pf.mem_addr), 64'h0);
        chk("rst_valid", 64'(pf.out_valid), 64'd0);
        repeat (16) cycle();
        chk("s1_count", 64'(pf.count), 64'd4);
        chk("s1_req", 64'(pf.mem_req), 64'd0);
        chk("s1_head_pc", 64'(pf.out_pc), 64'h0);

        // Drain while refilling with zero-wait memory.
        lat_min = 0; lat_max = 0; pop_pct = 100;
        repeat (6) cycle();

        // Flush while the request for 0x8 is pending, data arrives 3 cycles later.
        do_reset(0);
        lat_min = 1; lat_max = 1; pop_pct = 0;
        n = 0;
        while (!(outst && out_addr == 32'h8) && n < 40) begin cycle(); n++; end
        chk("s3_reach", 64'(outst && out_addr == 32'h8), 64'd1);
        lat_cnt = 3; force_flush = 1; force_pc = 32'h100;
        use_force_data = 1; force_data = 32'hDEAD_BEEF;
        repeat (5) cycle();
        use_force_data = 0;
`ifdef PREFETCH_STATS_EN
        chk("s3_discarded", 64'(stat_d), 64'd3);
`endif
        n = 0;
        while (!pf.out_valid && n < 20) begin cycle(); n++; end
        chk("s3_first_pc", 64'(pf.out_pc), 64'h100);

        // Flush in the same cycle as mem_ready.
        do_reset(0);
        n = 0;
        while (!(outst && out_addr == 32'h4) && n < 40) begin cycle(); n++; end
        chk("s4_reach", 64'(outst && out_addr == 32'h4), 64'd1);
        lat_cnt = 0; force_flush = 1; force_pc = 32'h200;
        cycle();
        chk("s4_count", 64'(pf.count), 64'd0);
        cycle();
        chk("s4_req", 64'(pf.mem_req), 64'd1);
        chk("s4_addr", 64'(pf.mem_addr), 64'h200);

        // Pops on an empty queue, then mixed traffic across pointer wrap.
        do_reset(0);
        pop_pct = 100; lat_min = 0; lat_max = 2;
        repeat (2) cycle();
        pop_pct = 50;
        repeat (40) cycle();

        // Reset during DROP, then a stray mem_ready.
        do_reset(0);
        pop_pct = 0; lat_min = 1; lat_max = 1;
        n = 0;
        while (!outst && n < 10) begin cycle(); n++; end
        lat_cnt = 10; force_flush = 1; force_pc = 32'h300;
        repeat (2) cycle();
        chk("s6_drop_req", 64'(pf.mem_req), 64'd0);
        do_reset(1);
        cycle();
        chk("s6_count", 64'(pf.count), 64'd0);
        chk("s6_addr", 64'(pf.mem_addr), 64'h0);

        // Long random run.
        lat_min = 0; lat_max = 3; pop_pct = 50; flush_pct = 3;
        repeat (1500) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
